rv32i_regfile_mp: RTL and testbench



---
 rtl/rv32i_regfile_mp_if.sv | 38 +++
 rtl/rv32i_regfile_mp.sv | 128 ++++++++++++
 tb/tb_rv32i_regfile_mp.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_regfile_mp_if.sv
// rtl/rv32i_regfile_mp_if.sv - operand/result/PC bus between core pipeline and register file
//
// Purpose: bundles every non-clock signal of rv32i_regfile_mp.
// Ports (signal directions seen from the register file, i.e. the slave modport):
//   write_i, rd_addr_i, data_i          write port
//   read_i, rs_addr_i                   read request, port p address at [p*REG_BITS +: REG_BITS]
//   rs_o                                read data, port p at [p*XLEN +: XLEN]
//   write_pc_i, increment_pc_i, data_pc_i, pc_o   program counter control and value
//   ready_o                             high once the post-reset clear sweep is done
interface rv32i_regfile_mp_if #(
    parameter int XLEN       = 32,
    parameter int REG_BITS   = 5,
    parameter int READ_PORTS = 2
);
    logic                           write_i;
    logic [REG_BITS-1:0]            rd_addr_i;
    logic [XLEN-1:0]                data_i;
    logic                           read_i;
    logic [READ_PORTS*REG_BITS-1:0] rs_addr_i;
    logic [READ_PORTS*XLEN-1:0]     rs_o;
    logic                           write_pc_i;
    logic                           increment_pc_i;
    logic [XLEN-1:0]                data_pc_i;
    logic [XLEN-1:0]                pc_o;
    logic                           ready_o;

    modport master (
        output write_i, rd_addr_i, data_i, read_i, rs_addr_i,
        output write_pc_i, increment_pc_i, data_pc_i,
        input  rs_o, pc_o, ready_o
    );

    modport slave (
        input  write_i, rd_addr_i, data_i, read_i, rs_addr_i,
        input  write_pc_i, increment_pc_i, data_pc_i,
        output rs_o, pc_o, ready_o
    );
endinterface

// File: rtl/rv32i_regfile_mp.sv
// rtl/rv32i_regfile_mp.sv - multi-read-port integer register file with program counter
//
// Purpose: READ_PORTS synchronous read ports, one write port, hardwired-zero x0,
// optional same-edge write-to-read bypass, and a post-reset sweep zeroing all registers.
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_i   asynchronous active-high reset
//   bus_io  rv32i_regfile_mp_if.slave (write/read ports, PC control, ready_o)
module rv32i_regfile_mp #(
    parameter int              XLEN       = 32,
    parameter int              REG_BITS   = 5,
    parameter int              READ_PORTS = 2,
    parameter int              BYPASS     = 1,
    parameter int              PC_INC     = 1,
    parameter logic [XLEN-1:0] PC_RESET   = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rv32i_regfile_mp_if.slave  bus_io
);
    localparam int DEPTH = 2**REG_BITS;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                     state_q;
    logic [REG_BITS-1:0]        clr_cnt_q;
    logic                       ready_q;
    logic [XLEN-1:0]            pc_q;
    logic [XLEN-1:0]            pc_d;
    logic [XLEN-1:0]            byp_data_q;
    logic [READ_PORTS*XLEN-1:0] rs_data;
    logic                       clear_we;
    logic                       wr_en;
    logic                       rd_en;

    // While clearing, the sweep owns the write port and all external requests are dropped.
    assign clear_we = (state_q == ST_CLEAR);
    assign wr_en    = (state_q == ST_READY) && bus_io.write_i && (bus_io.rd_addr_i != '0);
    assign rd_en    = (state_q == ST_READY) && bus_io.read_i;

    always_comb begin
        pc_d = pc_q;
        if (bus_io.write_pc_i) begin
            pc_d = bus_io.data_pc_i;
        end else if (bus_io.increment_pc_i) begin
            pc_d = pc_q + XLEN'(PC_INC);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            pc_q      <= PC_RESET;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + REG_BITS'(1);
                    if (clr_cnt_q == '1) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    pc_q <= pc_d;
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    // Write data is common to all ports, so one captured copy serves every bypassing port;
    // it only changes on an accepted read, together with the per-port select flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byp_data_q <= '0;
        end else if (rd_en) begin
            byp_data_q <= bus_io.data_i;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [XLEN-1:0]     mem [DEPTH];
        logic [XLEN-1:0]     rd_q;
        logic                zero_q;
        logic                byp_q;
        logic [REG_BITS-1:0] addr;
        logic                byp_hit;

        assign addr    = bus_io.rs_addr_i[p*REG_BITS +: REG_BITS];
        assign byp_hit = (BYPASS != 0) && bus_io.write_i
                         && (bus_io.rd_addr_i == addr) && (addr != '0);

        // Plain memory with registered read and no reset so it maps onto block RAM;
        // the non-blocking read returns pre-write contents on a same-address edge.
        always_ff @(posedge clk_i) begin
            if (clear_we) begin
                mem[clr_cnt_q] <= '0;
            end else if (wr_en) begin
                mem[bus_io.rd_addr_i] <= bus_io.data_i;
            end
            if (rd_en) begin
                rd_q <= mem[addr];
            end
        end

        // zero_q resets high so rs_o reads 0 from reset until the first accepted read,
        // masking the unreset RAM output register.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                zero_q <= 1'b1;
                byp_q  <= 1'b0;
            end else if (rd_en) begin
                zero_q <= (addr == '0);
                byp_q  <= byp_hit;
            end
        end

        assign rs_data[p*XLEN +: XLEN] = zero_q ? '0 : (byp_q ? byp_data_q : rd_q);
    end

    assign bus_io.rs_o    = rs_data;
    assign bus_io.pc_o    = pc_q;
    assign bus_io.ready_o = ready_q;
endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// tb/tb_rv32i_regfile_mp.sv - directed self-checking bench for rv32i_regfile_mp
module tb_rv32i_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    // a: 2 ports, bypass on, PC_INC 1, PC_RESET 0
    // b: 4 ports, bypass off, PC_INC 4, PC_RESET 0x1000
    rv32i_regfile_mp_if #(.XLEN(32), .REG_BITS(5), .READ_PORTS(2)) a_if ();
    rv32i_regfile_mp_if #(.XLEN(32), .REG_BITS(5), .READ_PORTS(4)) b_if ();

    rv32i_regfile_mp #(
        .XLEN(32), .REG_BITS(5), .READ_PORTS(2), .BYPASS(1), .PC_INC(1), .PC_RESET(32'h0)
    ) u_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(a_if.slave)
    );

    rv32i_regfile_mp #(
        .XLEN(32), .REG_BITS(5), .READ_PORTS(4), .BYPASS(0), .PC_INC(4), .PC_RESET(32'h1000)
    ) u_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(b_if.slave)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        a_if.write_i = 0; a_if.rd_addr_i = '0; a_if.data_i = '0; a_if.read_i = 0;
        a_if.rs_addr_i = '0; a_if.write_pc_i = 0; a_if.increment_pc_i = 0; a_if.data_pc_i = '0;
        b_if.write_i = 0; b_if.rd_addr_i = '0; b_if.data_i = '0; b_if.read_i = 0;
        b_if.rs_addr_i = '0; b_if.write_pc_i = 0; b_if.increment_pc_i = 0; b_if.data_pc_i = '0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        a_if.write_i = 1; a_if.rd_addr_i = addr; a_if.data_i = data;
        b_if.write_i = 1; b_if.rd_addr_i = addr; b_if.data_i = data;
    endtask

    task automatic rd(input logic [9:0] a_addr, input logic [19:0] b_addr);
        a_if.read_i = 1; a_if.rs_addr_i = a_addr;
        b_if.read_i = 1; b_if.rs_addr_i = b_addr;
    endtask

    // Counts rising edges from the current point until ready_o on instance a, bounded.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            #1;
        end while (!a_if.ready_o && cnt < 100);
    endtask

    task automatic read_all_zero(input string tag);
        for (int r = 0; r < 32; r++) begin
            rd({2{5'(r)}}, {4{5'(r)}});
            tick();
            check_eq($sformatf("%s_a_x%0d", tag, r), a_if.rs_o, '0);
            check_eq($sformatf("%s_b_x%0d", tag, r), b_if.rs_o, '0);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ready_a", a_if.ready_o, 0);
        check_eq("rst_rs_a", a_if.rs_o, '0);
        check_eq("rst_pc_a", a_if.pc_o, 32'h0);
        check_eq("rst_pc_b", b_if.pc_o, 32'h1000);

        rst = 1'b0;
        wait_ready(n);
        check_eq("sweep_edges", n, 32);
        check_eq("sweep_ready_b", b_if.ready_o, 1);
        @(negedge clk);
        read_all_zero("clr");

        // x5 write, then read x5 / x0
        wr(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        rd({5'd0, 5'd5}, {5'd5, 5'd5, 5'd0, 5'd5});
        tick();
        check_eq("x5_a", a_if.rs_o, {32'h0, 32'hDEADBEEF});
        check_eq("x5_b", b_if.rs_o, {32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF});
        idle();
        wr(5'd0, 32'h1234);
        tick();
        idle();
        rd('0, '0);
        tick();
        check_eq("x0_a", a_if.rs_o, '0);
        check_eq("x0_b", b_if.rs_o, '0);

        // same-edge write/read of x7 (previously 0x11)
        idle();
        wr(5'd7, 32'h11);
        tick();
        wr(5'd7, 32'hA5A5A5A5);
        rd({5'd5, 5'd7}, {4{5'd7}});
        tick();
        check_eq("byp_a", a_if.rs_o, {32'hDEADBEEF, 32'hA5A5A5A5});
        check_eq("nobyp_b", b_if.rs_o, {4{32'h11}});
        idle();
        rd({2{5'd7}}, {4{5'd7}});
        tick();
        check_eq("x7_a", a_if.rs_o, {2{32'hA5A5A5A5}});
        check_eq("x7_b", b_if.rs_o, {4{32'hA5A5A5A5}});

        // read_i low: outputs hold while addresses and contents change
        idle();
        for (int i = 0; i < 3; i++) begin
            wr(5'd7, 32'hFFFF0000 + 32'(i));
            a_if.rs_addr_i = {5'(i + 1), 5'd5};
            b_if.rs_addr_i = {4{5'(i)}};
            tick();
            check_eq($sformatf("hold_a_%0d", i), a_if.rs_o, {2{32'hA5A5A5A5}});
            check_eq($sformatf("hold_b_%0d", i), b_if.rs_o, {4{32'hA5A5A5A5}});
        end
        idle();
        wr(5'd9, 32'h99990009);
        tick();
        idle();
        rd({5'd7, 5'd9}, {4{5'd9}});
        tick();
        check_eq("x9x7_a", a_if.rs_o, {32'hFFFF0002, 32'h99990009});
        check_eq("x9_b", b_if.rs_o, {4{32'h99990009}});

        // PC
        idle();
        a_if.increment_pc_i = 1; b_if.increment_pc_i = 1;
        repeat (3) tick();
        check_eq("pc_inc3_a", a_if.pc_o, 32'h3);
        check_eq("pc_inc3_b", b_if.pc_o, 32'h100C);
        a_if.write_pc_i = 1; a_if.data_pc_i = 32'h100;
        b_if.write_pc_i = 1; b_if.data_pc_i = 32'h100;
        tick();
        check_eq("pc_prio_a", a_if.pc_o, 32'h100);
        check_eq("pc_prio_b", b_if.pc_o, 32'h100);
        idle();
        tick();
        check_eq("pc_hold_a", a_if.pc_o, 32'h100);
        a_if.write_pc_i = 1; a_if.data_pc_i = 32'hFFFFFFFF;
        b_if.write_pc_i = 1; b_if.data_pc_i = 32'hFFFFFFFF;
        tick();
        idle();
        a_if.increment_pc_i = 1; b_if.increment_pc_i = 1;
        tick();
        check_eq("pc_wrap_a", a_if.pc_o, 32'h0);
        check_eq("pc_wrap_b", b_if.pc_o, 32'h3);
        idle();

        // reset, then reset again mid-sweep at count 10
        rst = 1'b1;
        #1;
        check_eq("arst_ready_a", a_if.ready_o, 0);
        check_eq("arst_rs_a", a_if.rs_o, '0);
        check_eq("arst_pc_b", b_if.pc_o, 32'h1000);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick();
        check_eq("mid_ready_a", a_if.ready_o, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(5'd3, 32'hBAD);
        rd({2{5'd3}}, {4{5'd3}});
        a_if.write_pc_i = 1; a_if.increment_pc_i = 1; a_if.data_pc_i = 32'h77;
        b_if.write_pc_i = 1; b_if.increment_pc_i = 1; b_if.data_pc_i = 32'h77;
        wait_ready(n);
        check_eq("resweep_edges", n, 32);
        check_eq("resweep_pc_a", a_if.pc_o, 32'h0);
        check_eq("resweep_pc_b", b_if.pc_o, 32'h1000);
        check_eq("resweep_rs_a", a_if.rs_o, '0);
        check_eq("resweep_rs_b", b_if.rs_o, '0);
        @(negedge clk);
        idle();
        read_all_zero("reclr");
        check_eq("final_pc_b", b_if.pc_o, 32'h1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
